// File: rtl/fmap_stream_buffer_if.sv
// Bus bundle for fmap_stream_buffer: frame write port, random read port and
// the channel-major valid/ready output stream.
interface fmap_stream_buffer_if #(
    parameter int CH    = 16,
    parameter int DW    = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = (CH > 1) ? $clog2(CH) : 1
);
    logic             clear;
    logic             wr_valid;
    logic [CH*DW-1:0] wr_data;
    logic             frame_done;
    logic             overflow;
    logic             start;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic             m_last;
    logic             rd_req;
    logic [CW-1:0]    rd_ch;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data;
    logic             rd_ack;
    logic             busy;

    modport slave (
        input  clear, wr_valid, wr_data, start, m_ready, rd_req, rd_ch, rd_addr,
        output frame_done, overflow, m_valid, m_data, m_last, rd_data, rd_ack, busy
    );

    modport master (
        output clear, wr_valid, wr_data, start, m_ready, rd_req, rd_ch, rd_addr,
        input  frame_done, overflow, m_valid, m_data, m_last, rd_data, rd_ack, busy
    );
endinterface

// File: rtl/fmap_stream_buffer.sv
// One-frame CH x DEPTH x DW feature-map buffer: fills a frame, then serves
// random (channel, address) reads or drains it as a channel-major stream.
module fmap_stream_buffer #(
    parameter int CH    = 16,
    parameter int DW    = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fmap_stream_buffer_if.slave  bus
);
    localparam int MW = $clog2(DEPTH);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [1:0]       r_state;
    logic [MW-1:0]    r_wr_ptr;
    logic [MW-1:0]    r_rd_addr_ptr;
    logic [CW-1:0]    r_rd_ch_ptr;
    logic             r_fetch_done;
    logic             r_frame_done;
    logic             r_overflow;
    logic             r_rd_ack;
    logic [DW-1:0]    r_rd_data;
    logic [1:0]       r_cnt;
    logic [DW-1:0]    r_q0_data;
    logic [DW-1:0]    r_q1_data;
    logic             r_q0_last;
    logic             r_q1_last;
    logic [CH*DW-1:0] r_mem [DEPTH];

    logic             w_wr_en;
    logic             w_wr_last;
    logic             w_pop;
    logic             w_fetch;
    logic             w_fetch_last;
    logic [CH*DW-1:0] w_fetch_word;
    logic [DW-1:0]    w_fetch_data;
    logic [CH*DW-1:0] w_rd_word;
    logic             w_rd_in_range;

    function automatic logic [DW-1:0] pick(input logic [CH*DW-1:0] word,
                                           input logic [CW-1:0]    ch);
        // NOTE: default first so every path assigns the result; no latch is implied.
        pick = '0;
        for (int c = 0; c < CH; c++) begin
            if (ch == CW'(c)) pick = word[c*DW +: DW];
        end
    endfunction

    assign w_wr_en       = rst_n && !bus.clear && (r_state == ST_FILL) && bus.wr_valid;
    assign w_wr_last     = (r_wr_ptr == MW'(DEPTH - 1));
    assign w_pop         = (r_cnt != 2'd0) && bus.m_ready;
    assign w_fetch       = (r_state == ST_STREAM) && !r_fetch_done && (r_cnt != 2'd2);
    assign w_fetch_last  = (r_rd_ch_ptr == CW'(CH - 1)) && (r_rd_addr_ptr == MW'(DEPTH - 1));
    assign w_fetch_word  = r_mem[r_rd_addr_ptr];
    assign w_fetch_data  = pick(w_fetch_word, r_rd_ch_ptr);
    assign w_rd_word     = r_mem[bus.rd_addr[MW-1:0]];
    assign w_rd_in_range = (32'(bus.rd_addr) < DEPTH) && (32'(bus.rd_ch) < CH);

    // NOTE: storage has no reset; a word is only ever read after being written in FILL.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            r_state       <= ST_FILL;
            r_wr_ptr      <= '0;
            r_rd_addr_ptr <= '0;
            r_rd_ch_ptr   <= '0;
            r_fetch_done  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overflow    <= 1'b0;
            r_rd_ack      <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_rd_ack     <= 1'b0;
            if (bus.wr_valid && (r_state != ST_FILL)) r_overflow <= 1'b1;
            case (r_state)
                ST_FILL: begin
                    if (bus.wr_valid) begin
                        r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
                        if (w_wr_last) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.start) begin
                        r_state       <= ST_STREAM;
                        r_rd_addr_ptr <= '0;
                        r_rd_ch_ptr   <= '0;
                        r_fetch_done  <= 1'b0;
                    end else if (bus.rd_req) begin
                        r_rd_ack  <= 1'b1;
                        r_rd_data <= w_rd_in_range ? pick(w_rd_word, bus.rd_ch) : '0;
                    end
                end
                ST_STREAM: begin
                    // Fetch pointer walks addresses within a channel, then steps channel.
                    if (w_fetch) begin
                        if (r_rd_addr_ptr == MW'(DEPTH - 1)) begin
                            r_rd_addr_ptr <= '0;
                            r_rd_ch_ptr   <= w_fetch_last ? '0 : r_rd_ch_ptr + 1'b1;
                        end else begin
                            r_rd_addr_ptr <= r_rd_addr_ptr + 1'b1;
                        end
                        if (w_fetch_last) r_fetch_done <= 1'b1;
                    end
                    if (w_pop && r_q0_last) r_state <= ST_FILL;
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    // Two-entry output queue: q0 drives the stream, q1 absorbs the beat fetched
    // while the consumer stalls, so fetch never depends on m_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            r_cnt     <= 2'd0;
            r_q0_data <= '0;
            r_q1_data <= '0;
            r_q0_last <= 1'b0;
            r_q1_last <= 1'b0;
        end else begin
            case ({w_fetch, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_q0_data <= w_fetch_data;
                        r_q0_last <= w_fetch_last;
                    end else begin
                        r_q1_data <= w_fetch_data;
                        r_q1_last <= w_fetch_last;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_q0_data <= r_q1_data;
                    r_q0_last <= r_q1_last;
                    r_q1_last <= 1'b0;
                    r_cnt     <= r_cnt - 2'd1;
                end
                2'b11: begin
                    r_q0_data <= w_fetch_data;
                    r_q0_last <= w_fetch_last;
                end
                default: ;
            endcase
        end
    end

    assign bus.frame_done = r_frame_done;
    assign bus.overflow   = r_overflow;
    assign bus.m_valid    = (r_cnt != 2'd0);
    assign bus.m_data     = r_q0_data;
    assign bus.m_last     = r_q0_last;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_ack     = r_rd_ack;
    assign bus.busy       = (r_state == ST_STREAM);
endmodule

// File: doc/fmap_stream_buffer.md
# fmap_stream_buffer

Parametrised multi-channel feature-map buffer between a convolution layer's output stage and the next consumer (FC layer or host readout). It stores one frame of CH parallel channel words per address. The frame can be drained as a channel-major valid/ready stream, or sampled by random (channel, address) reads. It generalises the fixed 16-channel, 8-bit, select-by-index output path, and adds frame tracking, backpressure, overflow detection and a streaming mode.

## Interface
- CH, 16: channel count (≥1)
- DW, 8: bits per channel word
- DEPTH, 256: words per channel per frame (≥2)
- AW, $clog2(DEPTH): address width
- CW, $clog2(CH) (min 1): channel index width
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  abort/discard frame, return to FILL
- wr_valid  in  1  write one address word (all channels)
- wr_data  in  CH*DW  channel c at bits [c*DW +: DW]
- frame_done  out  1  one-cycle pulse when DEPTH-th write lands
- overflow  out  1  sticky: write attempted outside FILL; cleared by clear/reset
- start  in  1  begin streaming (honoured only in HOLD)
- m_valid  out  1  stream beat valid
- m_ready  in  1  consumer accepts beat
- m_data  out  DW  stream word
- m_last  out  1  high on final beat (ch CH-1, addr DEPTH-1)
- rd_req  in  1  random read request (honoured only in HOLD)
- rd_ch  in  CW  channel index
- rd_addr  in  AW  word address
- rd_data  out  DW  random read result
- rd_ack  out  1  one-cycle pulse, rd_data valid
- busy  out  1  high in STREAM

## Operation
- States: FILL, HOLD, STREAM. Reset and clear both enter FILL.
- FILL:
  - Each wr_valid writes wr_data at wr_ptr, then increments wr_ptr.
  - On the write with wr_ptr==DEPTH-1: wr_ptr wraps to 0, frame_done pulses, state moves to HOLD.
- HOLD:
  - wr_valid is dropped and sets overflow.
  - rd_req reads word rd_addr of channel rd_ch.
  - rd_ch ≥ CH or rd_addr ≥ DEPTH returns rd_data=0, still with rd_ack.
  - start moves to STREAM with rd_ch_ptr=0 and rd_addr_ptr=0.
  - If start and rd_req arrive in the same cycle, start wins and rd_req is ignored.
- STREAM:
  - Emits CH*DEPTH beats in channel-major order: ch0 addr0..DEPTH-1, then ch1, and so on.
  - The address pointer advances on each beat; when it wraps, the channel pointer increments.
  - After the beat with m_last is accepted (m_valid&&m_ready), state moves to FILL and the buffer is free for the next frame.
  - wr_valid is dropped (sets overflow); rd_req and start are ignored.
- Priority in any state: rst_n=0 over clear over all other inputs.
- clear during STREAM: m_valid drops the next cycle, pending beats are discarded, pointers reset, overflow cleared.
- Storage is CH×DEPTH×DW. Channel slice is selected by index×DW. No arithmetic is applied to the data.

## Timing
- Reset values: frame_done=0, overflow=0, m_valid=0, m_data=0, m_last=0, rd_data=0, rd_ack=0, busy=0, state=FILL, all pointers 0.
- Write: data written on the edge where wr_valid is sampled. frame_done is asserted in the cycle after the final write.
- Random read: rd_req sampled at edge t gives rd_ack=1 and rd_data valid in cycle t+1. rd_data holds until the next rd_ack.
- Stream:
  - start sampled at edge t; busy=1 from t+1; first m_valid at t+2.
  - With m_ready held high: one beat per cycle with no bubbles.
  - While m_valid&&!m_ready: m_data and m_last hold stable and no beat is lost. An internal skid or 2-entry output buffer is required.
  - After the m_last handshake: m_valid=0 and busy=0 the next cycle. A wr_valid in that cycle is accepted as address 0.
- clear, or rst_n low, at edge t: all outputs are at reset values from cycle t+1.

## Test plan
- CH=4, DEPTH=8. Write 8 words, channel c of word a = {c[3:0],a[3:0]} -> frame_done pulses once, one cycle after the 8th write; state is HOLD.
- HOLD, rd_req with rd_ch=2, rd_addr=5 -> rd_ack one cycle later, rd_data=8'h25. rd_ch=4 -> rd_data=0 with rd_ack.
- start with m_ready=1 -> 32 beats 00,01..07,10..37 on consecutive cycles; m_last only on 8'h37; then FILL, busy=0.
- Same stream with m_ready toggled 1,0,0,1 pseudo-randomly -> the identical 32-beat sequence; m_data stable on every stall cycle.
- wr_valid in HOLD -> overflow=1 and stored data unchanged (re-read addr 0 ch 0 = 00). clear -> overflow=0, state FILL.
- clear asserted after beat 10 of the stream -> m_valid=0 next cycle. A new frame write plus stream then outputs the new data starting at ch0 addr0.
